// File: rtl/gray_counter_pkg.sv
// gray_counter_pkg: shared state type, Gray helper and default prescale for gray_step_counter
package gray_counter_pkg;
  typedef enum logic {PAUSE, RUN} state_t;
  localparam int DEFAULT_DIV_COUNT = 50_000_000;
  localparam int GRAY_MAX_W = 32;
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray_step_counter_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability filter when GRAY_CNT_DEBOUNCE_EN is defined, rising-edge pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);
  logic s1_q, s2_q, edge_q, lvl;
`ifdef GRAY_CNT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic flt_q, flt_d;
  // any sample that matches the filtered level restarts the stability count
  always_comb begin
    cnt_d = '0;
    flt_d = flt_q;
    if (s2_q != flt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) flt_d = s2_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      flt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      flt_q <= flt_d;
    end
  end
  assign lvl = flt_q;
`else
  assign lvl = s2_q | (DEBOUNCE_CYCLES < 0);
`endif
  always_ff @(posedge clk) begin
    if (rst) {s1_q, s2_q, edge_q} <= '0;
    else {s1_q, s2_q, edge_q} <= {btn_i, s1_q, lvl};
  end
  assign rise_o = lvl & ~edge_q;
endmodule

// File: rtl/gray_step_counter.sv
// gray_step_counter: run/pause Gray counter with prescaler and up/down; GRAY_CNT_DEBOUNCE_EN adds a button filter
module gray_step_counter
  import gray_counter_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DIV_COUNT       = DEFAULT_DIV_COUNT,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START_STOP,
  input  logic             DIR_UP,
  input  logic             CLEAR,
  output logic [WIDTH-1:0] GRAY_OUT,
  output logic [WIDTH-1:0] BIN_OUT,
  output logic             STEP,
  output logic             RUNNING
);
  localparam int PW = $clog2(DIV_COUNT);
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] bin_q, bin_d, gray_q, gray_d;
  logic step_q, step_d, toggle, tc;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk(CLK), .rst(RST), .btn_i(START_STOP), .rise_o(toggle)
  );
  // a toggle coinciding with terminal count only happens in RUN, so it drops that step
  always_comb begin
    state_d = toggle ? (state_q == RUN ? PAUSE : RUN) : state_q;
    tc = state_q == RUN && presc_q == PW'(DIV_COUNT - 1);
    step_d = tc && !toggle && !CLEAR;
    presc_d = (CLEAR || tc || (state_q == PAUSE && toggle)) ? '0
            : state_q == RUN ? presc_q + 1'b1 : presc_q;
    bin_d = CLEAR ? '0 : step_d ? (DIR_UP ? bin_q + 1'b1 : bin_q - 1'b1) : bin_q;
    gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= PAUSE;
      presc_q <= '0;
      bin_q <= '0;
      gray_q <= '0;
      step_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bin_q <= bin_d;
      gray_q <= gray_d;
      step_q <= step_d;
    end
  end
  assign GRAY_OUT = gray_q;
  assign BIN_OUT = bin_q;
  assign STEP = step_q;
  assign RUNNING = state_q == RUN;
endmodule

// File: tb/tb_gray_step_counter.sv
// tb_gray_step_counter: scoreboard bench for gray_step_counter, WIDTH=3 DIV_COUNT=4 DEBOUNCE_CYCLES=8
module tb_gray_step_counter;
`ifdef GRAY_CNT_DEBOUNCE_EN
  localparam int TOG = 11;
`else
  localparam int TOG = 3;
`endif
  logic CLK = 1'b0, RST = 1'b1, START_STOP = 1'b0, DIR_UP = 1'b1, CLEAR = 1'b0;
  logic [2:0] GRAY_OUT, BIN_OUT;
  logic STEP, RUNNING;
  gray_step_counter #(.WIDTH(3), .DIV_COUNT(4), .DEBOUNCE_CYCLES(8)) dut (
    .CLK(CLK), .RST(RST), .START_STOP(START_STOP), .DIR_UP(DIR_UP), .CLEAR(CLEAR),
    .GRAY_OUT(GRAY_OUT), .BIN_OUT(BIN_OUT), .STEP(STEP), .RUNNING(RUNNING)
  );
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  typedef struct {logic [2:0] b; logic [2:0] g; int c;} exp_t;
  exp_t q[$];
  exp_t me;
  logic [2:0] gt [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
  int pass_n = 0, tot_n = 0;
  task automatic chk(input string name, input int act, input int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic push(input int b, input int c);
    exp_t e;
    e.b = 3'(b);
    e.g = gt[3'(b)];
    e.c = c;
    q.push_back(e);
  endtask
  task automatic wait_until(input int c);
    if (cyc > c) chk("schedule", cyc, c);
    while (cyc < c) @(negedge CLK);
  endtask
  task automatic press(input int hi, input int lo);
    START_STOP = 1'b1;
    repeat (hi) @(negedge CLK);
    START_STOP = 1'b0;
    repeat (lo) @(negedge CLK);
  endtask
  always @(negedge CLK) begin
    if (STEP === 1'b1) begin
      if (q.size() == 0) chk("unexpected_step", cyc, -1);
      else begin
        me = q.pop_front();
        chk("step_cycle", cyc, me.c);
        chk("step_bin", int'(BIN_OUT), int'(me.b));
        chk("step_gray", int'(GRAY_OUT), int'(me.g));
      end
    end
  end
  initial begin
    int t, c;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk("rst_gray", int'(GRAY_OUT), 0);
    chk("rst_bin", int'(BIN_OUT), 0);
    chk("rst_running", int'(RUNNING), 0);
    chk("rst_step", int'(STEP), 0);
    repeat (50) @(negedge CLK);
    // count up through wrap
    t = cyc + TOG;
    for (int k = 1; k <= 8; k++) push(k % 8, t + 4 * k);
    press(10, 12);
    chk("run_on", int'(RUNNING), 1);
    wait_until(t + 33);
    DIR_UP = 1'b0;
    push(7, t + 36); push(6, t + 40); push(5, t + 44);
    // clear at bin 5, prescaler restarts from the clear edge
    wait_until(t + 45);
    CLEAR = 1'b1;
    DIR_UP = 1'b1;
    push(1, t + 50); push(2, t + 54);
    @(negedge CLK);
    CLEAR = 1'b0;
    chk("clr_bin", int'(BIN_OUT), 0);
    chk("clr_gray", int'(GRAY_OUT), 0);
    chk("clr_running", int'(RUNNING), 1);
    chk("clr_step", int'(STEP), 0);
    // pause landing on terminal count at t+58 drops that step
    wait_until(t + 58 - TOG);
    press(10, 12);
    repeat (10) @(negedge CLK);
    chk("pause_running", int'(RUNNING), 0);
    chk("pause_bin", int'(BIN_OUT), 2);
    chk("pause_gray", int'(GRAY_OUT), 3);
    c = cyc;
    for (int k = 1; k <= 6; k++) push((2 + k) % 8, c + TOG + 4 * k);
    press(10, 12);
    wait_until(c + TOG + 25);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_rst_bin", int'(BIN_OUT), 0);
    chk("mid_rst_gray", int'(GRAY_OUT), 0);
    chk("mid_rst_running", int'(RUNNING), 0);
    chk("mid_rst_step", int'(STEP), 0);
    repeat (30) @(negedge CLK);
    // 3-cycle glitch
    c = cyc;
    START_STOP = 1'b1;
    repeat (3) @(negedge CLK);
    START_STOP = 1'b0;
`ifdef GRAY_CNT_DEBOUNCE_EN
    wait_until(c + 20);
    chk("glitch_running", int'(RUNNING), 0);
    c = cyc;
    START_STOP = 1'b1;
    wait_until(c + 10);
    START_STOP = 1'b0;
    chk("press_edge10", int'(RUNNING), 0);
    @(negedge CLK);
    chk("press_edge11", int'(RUNNING), 1);
`else
    chk("glitch_edge3", int'(RUNNING), 1);
    for (int k = 1; k <= 4; k++) push(k, c + 3 + 4 * k);
    wait_until(c + 20);
    chk("glitch_running", int'(RUNNING), 1);
`endif
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: cycle %0d reached without completion", cyc);
    $fatal(1);
  end
endmodule
